mbist_resp_checker: RTL and testbench

//  Response analyser for the SRAM MBIST path. Watches generator strobes (addr, data, we,

---
 rtl/mbist_resp_checker_if.sv | 31 +++
 rtl/mbist_resp_checker.sv | 159 +++++++++++++++
 tb/tb_mbist_resp_checker.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_resp_checker_if.sv
// Signal bundle between the MBIST generator/SRAM side and the response checker.
// master: generator + SRAM side (drives strobes and q); slave: the checker.
interface mbist_resp_checker_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 9
);
    logic              cen;
    logic [ADDR_W-1:0] gen_addr;
    logic [DATA_W-1:0] gen_data;
    logic              gen_we;
    logic              gen_cout;
    logic [DATA_W-1:0] sram_q;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [CNT_W-1:0]  fail_cnt;
    logic [DATA_W-1:0] fail_syn;

    modport master (
        output cen, gen_addr, gen_data, gen_we, gen_cout, sram_q,
        input  busy, done, pass, fail, fail_addr, fail_cnt, fail_syn
    );

    modport slave (
        input  cen, gen_addr, gen_data, gen_we, gen_cout, sram_q,
        output busy, done, pass, fail, fail_addr, fail_cnt, fail_syn
    );
endinterface

// File: rtl/mbist_resp_checker.sv
// MBIST response analyser: aligns expected read data to SRAM latency, flags mismatches,
// keeps sticky fail / first address / saturating count. Define MBIST_FAIL_SYN_EN for the syndrome.
module mbist_resp_checker #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 9
) (
    input logic                 clk,
    input logic                 rst,
    mbist_resp_checker_if.slave bus
);
    localparam int unsigned DCNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
    } pipe_t;

    state_t            state;
    logic [DCNT_W-1:0] drain_cnt;
    pipe_t             pipe [RD_LAT];

    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              fail_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [CNT_W-1:0]  fail_cnt_q;

    logic              active_c;
    logic              issue_c;
    logic              mism_c;
    pipe_t             pipe_in_c;
    pipe_t             pipe_out_c;

    // Read issue, pipe head/tail and the compare itself
    always_comb begin
        active_c   = (state == S_RUN) || (state == S_DRAIN);
        issue_c    = (state == S_RUN) && bus.cen && !bus.gen_we && !bus.gen_cout;
        pipe_in_c  = '0;
        pipe_in_c.vld  = issue_c;
        pipe_in_c.addr = issue_c ? bus.gen_addr : '0;
        pipe_in_c.exp  = issue_c ? bus.gen_data : '0;
        pipe_out_c = pipe[RD_LAT-1];
        mism_c     = active_c && pipe_out_c.vld && (bus.sram_q != pipe_out_c.exp);
    end

    // Expected-value delay line, matches SRAM read latency; frozen outside RUN/DRAIN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe[i] <= '0;
            end
        end else if (active_c) begin
            pipe[0] <= pipe_in_c;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Sequencing FSM with registered busy/done/pass
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.gen_cout) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        pass_q <= !fail_q;
                    end else if (bus.cen) begin
                        state  <= S_RUN;
                        busy_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.gen_cout) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    // Last issued read reaches the compare before this count expires
                    if (drain_cnt == DCNT_W'(RD_LAT - 1)) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= !(fail_q || mism_c);
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky fail, first failing address, saturating count
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
        end else if (mism_c) begin
            fail_q <= 1'b1;
            if (fail_cnt_q != '1) begin
                fail_cnt_q <= fail_cnt_q + 1'b1;
            end
            if (!fail_q) begin
                fail_addr_q <= pipe_out_c.addr;
            end
        end
    end

`ifdef MBIST_FAIL_SYN_EN
    logic [DATA_W-1:0] fail_syn_q;

    // Bit-level syndrome of the first failure only
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_syn_q <= '0;
        end else if (mism_c && !fail_q) begin
            fail_syn_q <= bus.sram_q ^ pipe_out_c.exp;
        end
    end

    assign bus.fail_syn = fail_syn_q;
`else
    assign bus.fail_syn = '0;
`endif

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.fail_addr = fail_addr_q;
    assign bus.fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_mbist_resp_checker.sv
// Bench for mbist_resp_checker: march-style generator, faulty SRAM model with latency,
// transaction-level reference of issued reads. Three DUTs: RD_LAT=1, RD_LAT=3, CNT_W=2.
module tb_mbist_resp_checker;
    logic       clk = 1'b0;
    logic       rst;
    logic       cen, we, cout;
    logic [7:0] addr;
    logic [3:0] data;

    logic [3:0] mem   [256];
    logic [3:0] smask [256];
    logic [3:0] sval  [256];
    logic [3:0] q1;
    logic [3:0] q3    [3];

    logic [3:0] ref_mem [256];
    logic [3:0] pat [4];
    int         m_cnt;
    logic [7:0] m_addr;
    logic [3:0] m_syn;
    bit         m_started;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mbist_resp_checker_if #(.ADDR_W(8), .DATA_W(4), .CNT_W(9)) ifa ();
    mbist_resp_checker_if #(.ADDR_W(8), .DATA_W(4), .CNT_W(9)) ifb ();
    mbist_resp_checker_if #(.ADDR_W(8), .DATA_W(4), .CNT_W(2)) ifc ();

    assign ifa.cen = cen;  assign ifa.gen_addr = addr; assign ifa.gen_data = data;
    assign ifa.gen_we = we; assign ifa.gen_cout = cout; assign ifa.sram_q = q1;
    assign ifb.cen = cen;  assign ifb.gen_addr = addr; assign ifb.gen_data = data;
    assign ifb.gen_we = we; assign ifb.gen_cout = cout; assign ifb.sram_q = q3[2];
    assign ifc.cen = cen;  assign ifc.gen_addr = addr; assign ifc.gen_data = data;
    assign ifc.gen_we = we; assign ifc.gen_cout = cout; assign ifc.sram_q = q1;

    mbist_resp_checker #(.ADDR_W(8), .DATA_W(4), .RD_LAT(1), .CNT_W(9)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mbist_resp_checker #(.ADDR_W(8), .DATA_W(4), .RD_LAT(3), .CNT_W(9)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    mbist_resp_checker #(.ADDR_W(8), .DATA_W(4), .RD_LAT(1), .CNT_W(2)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    function automatic logic [3:0] faulty(input logic [7:0] a, input logic [3:0] v);
        return (v & ~smask[a]) | (sval[a] & smask[a]);
    endfunction

    // SRAM model: registered read through stuck-at faults, delayed 1 or 3 cycles
    always @(posedge clk) begin
        q1    <= faulty(addr, mem[addr]);
        q3[0] <= faulty(addr, mem[addr]);
        q3[1] <= q3[0];
        q3[2] <= q3[1];
        if (cen && we) mem[addr] <= data;
    end

    task automatic clear_faults();
        for (int i = 0; i < 256; i++) begin smask[i] = '0; sval[i] = '0; end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_addr = '0; m_syn = '0; m_started = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cen = 1'b0; cout = 1'b0; we = 1'b0; addr = '0; data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // Generator: 8 phases over 256 addresses (W p0, R p0, W p1, R p1, ...); model tracks issued reads
    task automatic run_seq(input bit rand_cen, input int n_ops);
        int i = 0;
        int cyc = 0;
        logic [3:0] obs;
        while (i < n_ops && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            cen  = rand_cen ? 1'($urandom_range(0, 1)) : 1'b1;
            addr = 8'(i % 256);
            we   = ((i / 256) % 2) == 0;
            data = pat[(i / 256) / 2];
            cout = 1'b0;
            if (cen) begin
                if (!m_started) m_started = 1;
                else if (!we) begin
                    obs = faulty(addr, ref_mem[addr]);
                    if (obs != data) begin
                        if (m_cnt == 0) begin m_addr = addr; m_syn = obs ^ data; end
                        m_cnt++;
                    end
                end
                if (we) ref_mem[addr] = data;
                i++;
            end
        end
        n_vec++;
        if (i != n_ops) begin n_err++; $display("FAIL run_seq_budget ops=%0d required=%0d", i, n_ops); end
    endtask

    // Raise gen_cout for one cycle; report how many edges after it done_a / done_b rose
    task automatic end_seq(output int off_a, output int off_b);
        @(negedge clk);
        n_vec++;
        if (ifa.busy !== 1'b1) begin n_err++; $display("FAIL busy_in_run got %0b required 1", ifa.busy); end
        cen = 1'b1; we = 1'b0; cout = 1'b1; addr = '0; data = '0;
        off_a = -1; off_b = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin cout = 1'b0; cen = 1'b0; end
            if (off_a < 0 && ifa.done === 1'b1) off_a = k;
            if (off_b < 0 && ifb.done === 1'b1) off_b = k;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({ifa.busy, ifa.done, ifa.pass, ifa.fail, ifa.fail_addr, ifa.fail_cnt, ifa.fail_syn} !== '0) begin
            n_err++; $display("FAIL reset_a got %b required 0", {ifa.busy, ifa.done, ifa.pass, ifa.fail, ifa.fail_addr, ifa.fail_cnt, ifa.fail_syn});
        end
        n_vec++;
        if ({ifb.busy, ifb.done, ifb.pass, ifb.fail, ifb.fail_addr, ifb.fail_cnt} !== '0) begin
            n_err++; $display("FAIL reset_b got %b required 0", {ifb.busy, ifb.done, ifb.pass, ifb.fail, ifb.fail_addr, ifb.fail_cnt});
        end
        n_vec++;
        if ({ifc.busy, ifc.done, ifc.pass, ifc.fail, ifc.fail_cnt} !== '0) begin
            n_err++; $display("FAIL reset_c got %b required 0", {ifc.busy, ifc.done, ifc.pass, ifc.fail, ifc.fail_cnt});
        end
    endtask

    task automatic test_empty();
        do_reset();
        @(negedge clk); cout = 1'b1;
        @(negedge clk); cout = 1'b0;
        n_vec++;
        if ({ifa.done, ifa.pass, ifa.busy} !== 3'b110) begin
            n_err++; $display("FAIL empty_run got done/pass/busy=%b required 110", {ifa.done, ifa.pass, ifa.busy});
        end
    endtask

    task automatic test_clean();
        int oa, ob;
        pat = '{4'h0, 4'hF, 4'h5, 4'h3};
        clear_faults(); do_reset(); run_seq(1'b0, 2048); end_seq(oa, ob);
        n_vec++;
        if ({ifa.done, ifa.pass, ifa.fail} !== 3'b110) begin
            n_err++; $display("FAIL clean_status got done/pass/fail=%b required 110", {ifa.done, ifa.pass, ifa.fail});
        end
        n_vec++;
        if (ifa.fail_cnt !== 9'd0) begin n_err++; $display("FAIL clean_cnt got %0d required 0", ifa.fail_cnt); end
        n_vec++;
        if (oa != 1) begin n_err++; $display("FAIL clean_done_lat1 got %0d required 1", oa); end
    endtask

    task automatic test_stuck();
        int oa, ob;
        logic [3:0] exp_syn;
        pat = '{4'h0, 4'hF, 4'h5, 4'h3};
        clear_faults(); smask[8'h05] = 4'b0001; sval[8'h05] = 4'b0001;
        do_reset(); run_seq(1'b0, 2048); end_seq(oa, ob);
`ifdef MBIST_FAIL_SYN_EN
        exp_syn = m_syn;
`else
        exp_syn = 4'b0000;
`endif
        n_vec++;
        if ({ifa.fail, ifa.pass, ifa.done} !== 3'b101) begin
            n_err++; $display("FAIL stuck_status got fail/pass/done=%b required 101", {ifa.fail, ifa.pass, ifa.done});
        end
        n_vec++;
        if (ifa.fail_addr !== 8'h05 || ifa.fail_addr !== m_addr) begin
            n_err++; $display("FAIL stuck_addr got %h required 05 (model %h)", ifa.fail_addr, m_addr);
        end
        n_vec++;
        if (ifa.fail_cnt !== 9'd1 || int'(ifa.fail_cnt) != m_cnt) begin
            n_err++; $display("FAIL stuck_cnt got %0d required 1 (model %0d)", ifa.fail_cnt, m_cnt);
        end
        n_vec++;
        if (ifa.fail_syn !== exp_syn) begin n_err++; $display("FAIL stuck_syn got %b required %b", ifa.fail_syn, exp_syn); end
        n_vec++;
        if (ifb.fail_addr !== 8'h05 || ifb.fail_cnt !== 9'd1) begin
            n_err++; $display("FAIL stuck_lat3 got addr %h cnt %0d required 05/1", ifb.fail_addr, ifb.fail_cnt);
        end
    endtask

    task automatic test_two_fails();
        int oa, ob;
        pat = '{4'h0, 4'hF, 4'h5, 4'h3};
        clear_faults();
        smask[8'h10] = 4'b0001; sval[8'h10] = 4'b0001;
        smask[8'h20] = 4'b0001; sval[8'h20] = 4'b0001;
        do_reset(); run_seq(1'b0, 2048); end_seq(oa, ob);
        n_vec++;
        if (ifa.fail_addr !== 8'h10 || ifa.fail_cnt !== 9'd2 || m_cnt != 2) begin
            n_err++; $display("FAIL two_fails got addr %h cnt %0d required 10/2 (model cnt %0d)", ifa.fail_addr, ifa.fail_cnt, m_cnt);
        end
    endtask

    task automatic test_lat3_random_cen();
        int oa, ob;
        for (int p = 0; p < 4; p++) pat[p] = 4'($urandom_range(0, 15));
        clear_faults(); do_reset(); run_seq(1'b1, 2048); end_seq(oa, ob);
        n_vec++;
        if ({ifb.done, ifb.pass, ifb.fail} !== 3'b110 || ifb.fail_cnt !== 9'd0) begin
            n_err++; $display("FAIL lat3_status got done/pass/fail=%b cnt %0d required 110/0", {ifb.done, ifb.pass, ifb.fail}, ifb.fail_cnt);
        end
        n_vec++;
        if (ob != 3) begin n_err++; $display("FAIL lat3_done_delay got %0d required 3", ob); end
        n_vec++;
        if (oa != 1) begin n_err++; $display("FAIL lat1_done_delay got %0d required 1", oa); end
    endtask

    task automatic test_random_faults();
        int oa, ob;
        int exp_c;
        logic [7:0] a;
        logic [3:0] exp_syn;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 4; p++) pat[p] = 4'($urandom_range(0, 15));
            clear_faults();
            for (int f = 0; f < 4; f++) begin
                a = 8'($urandom_range(1, 255));
                smask[a] = 4'($urandom_range(1, 15));
                sval[a]  = 4'($urandom_range(0, 15));
            end
            do_reset(); run_seq(1'b1, 2048); end_seq(oa, ob);
            exp_c = (m_cnt > 3) ? 3 : m_cnt;
`ifdef MBIST_FAIL_SYN_EN
            exp_syn = m_syn;
`else
            exp_syn = 4'b0000;
`endif
            n_vec++;
            if (int'(ifa.fail_cnt) != m_cnt || ifa.fail !== (m_cnt != 0) || ifa.pass !== (m_cnt == 0)) begin
                n_err++; $display("FAIL rand_a_status got cnt %0d fail %b pass %b required cnt %0d", ifa.fail_cnt, ifa.fail, ifa.pass, m_cnt);
            end
            n_vec++;
            if (m_cnt != 0 && (ifa.fail_addr !== m_addr || ifa.fail_syn !== exp_syn)) begin
                n_err++; $display("FAIL rand_a_first got addr %h syn %b required %h/%b", ifa.fail_addr, ifa.fail_syn, m_addr, exp_syn);
            end
            n_vec++;
            if (int'(ifb.fail_cnt) != m_cnt || (m_cnt != 0 && ifb.fail_addr !== m_addr)) begin
                n_err++; $display("FAIL rand_b got cnt %0d addr %h required %0d/%h", ifb.fail_cnt, ifb.fail_addr, m_cnt, m_addr);
            end
            n_vec++;
            if (int'(ifc.fail_cnt) != exp_c) begin n_err++; $display("FAIL rand_c_sat got %0d required %0d", ifc.fail_cnt, exp_c); end
        end
    endtask

    task automatic test_saturate();
        int oa, ob;
        pat = '{4'h0, 4'hF, 4'h5, 4'h3};
        clear_faults();
        for (int f = 0; f < 6; f++) begin smask[8'(3 + 7 * f)] = 4'b0001; sval[8'(3 + 7 * f)] = 4'b0001; end
        do_reset(); run_seq(1'b0, 2048); end_seq(oa, ob);
        n_vec++;
        if (ifc.fail_cnt !== 2'b11) begin n_err++; $display("FAIL sat_cnt_w2 got %b required 11", ifc.fail_cnt); end
        n_vec++;
        if (ifa.fail_cnt !== 9'd6 || m_cnt != 6) begin
            n_err++; $display("FAIL sat_cnt_w9 got %0d required 6 (model %0d)", ifa.fail_cnt, m_cnt);
        end
    endtask

    task automatic test_rst_mid_run();
        int oa, ob;
        pat = '{4'h0, 4'hF, 4'h5, 4'h3};
        clear_faults(); smask[8'h02] = 4'b0001; sval[8'h02] = 4'b0001;
        do_reset(); run_seq(1'b0, 600);
        @(negedge clk);
        n_vec++;
        if ({ifa.fail, ifa.busy} !== 2'b11) begin n_err++; $display("FAIL midrun_pre got fail/busy=%b required 11", {ifa.fail, ifa.busy}); end
        rst = 1'b1; cen = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ifa.busy, ifa.done, ifa.pass, ifa.fail, ifa.fail_addr, ifa.fail_cnt, ifa.fail_syn} !== '0) begin
            n_err++; $display("FAIL midrun_rst got %b required 0", {ifa.busy, ifa.done, ifa.pass, ifa.fail, ifa.fail_addr, ifa.fail_cnt, ifa.fail_syn});
        end
        rst = 1'b0;
        clear_faults(); model_clear(); run_seq(1'b0, 2048); end_seq(oa, ob);
        n_vec++;
        if ({ifa.done, ifa.pass} !== 2'b11 || ifa.fail_cnt !== 9'd0) begin
            n_err++; $display("FAIL midrun_rerun got done/pass=%b cnt %0d required 11/0", {ifa.done, ifa.pass}, ifa.fail_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; we = 1'b0; cout = 1'b0; addr = '0; data = '0;
        for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        clear_faults();
        test_reset();
        test_empty();
        test_clean();
        test_stuck();
        test_two_fails();
        test_lat3_random_cen();
        test_random_faults();
        test_saturate();
        test_rst_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
